rnn_mem_responder: RTL
======================

Name: rnn_mem_responder

Overview:
- Memory- and stream-side responder for the RNN engine: answers its mce/msel/maddr read requests from internal weight, bias and header banks, and supplies 32-bit input vectors on the engine's i_en pulls.
- Captures the engine's hidden-state writes (msel=101) and forwards them on an output stream.
- Sequences one run: arm, assert ready, observe busy, signal done.
- Sits between the host/loader and the engine.

Parameters:
- H, 64, hidden size; bias bank depth; h index width 6.
- X, 32, input vector width in bits; W_ih row length.
- DW, 20, weight/bias/state word width.
- FIFO_DEPTH, 4, input-vector FIFO entries (power of two).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cfg_we  in  1  host config write strobe.
- cfg_sel  in  3  config target bank (same encoding as msel).
- cfg_addr  in  17  config word address.
- cfg_data  in  20  config write data.
- in_valid  in  1  host input vector valid.
- in_data  in  32  host input vector.
- in_ready  out  1  input FIFO not full.
- start  in  1  one-cycle arm request.
- ready  out  1  to engine: run may begin.
- busy  in  1  from engine.
- i_en  in  1  from engine: input pull.
- idata  out  32  to engine: input FIFO head.
- mce  in  1  from engine: memory enable.
- msel  in  3  from engine: bank select.
- maddr  in  17  from engine: word address.
- mdata_w  in  20  from engine: write data.
- mdata_r  out  20  to engine: read data.
- out_valid  out  1  hidden-state word valid (one cycle).
- out_addr  out  17  {t, h} address of the word.
- out_data  out  20  hidden-state word.
- done  out  1  one-cycle run-complete pulse.
- err  out  1  sticky protocol error.

Behaviour:
- Banks, selected by msel/cfg_sel:
  - 000 W_ih: 2048 words, address {h[5:0], x[4:0]}.
  - 001 b_ih: 64 words, address h.
  - 010 W_hh: 4096 words, address {h_row[5:0], h_col[5:0]}.
  - 011 b_hh: 64 words, address h.
  - 100 header: address 0 is the seq_len register; other addresses read 0.
  - 101 output: write-only from the engine; reads return 0.
  - 110/111: unused; read 0.
- Read path is combinational:
  - mdata_r = bank[msel][maddr] whenever mce=1, so data is valid in the same cycle the address is presented.
  - mdata_r = 0 when mce=0.
  - Bits of maddr above the bank's index width must be 0. Otherwise mdata_r = 0 and err sets.
- Engine writes:
  - On a posedge with mce=1, msel=101 and state RUN: out_valid=1, out_addr=maddr, out_data=mdata_w on the next cycle. No internal storage.
  - A write to msel 101 outside RUN is dropped and sets err.
- Config writes:
  - Committed on a posedge with cfg_we=1 only in IDLE or DONE.
  - Ignored and err sets in ARMED or RUN.
  - cfg_sel 101, 110 or 111 is ignored.
- Input FIFO (first-word fall-through):
  - Push on in_valid & in_ready.
  - idata = head entry, or 0 when empty.
  - Pop on each posedge with i_en=1 in ARMED or RUN.
  - Pop when empty: no change, sets err.
  - Simultaneous push and pop while full: pop takes effect and the push is refused (in_ready=0 that cycle).
- State machine:
  - IDLE: start=1 -> ARMED.
  - ARMED: ready=1 while FIFO non-empty. busy=1 sampled -> RUN and ready=0 from the next cycle.
  - RUN: busy falls to 0 -> DONE, with done=1 for exactly one cycle (the cycle DONE is entered).
  - DONE: start -> ARMED. Config allowed.
  - start in ARMED or RUN is ignored.
- Reset: state IDLE; FIFO emptied; ready, out_valid, done, err = 0; out_addr, out_data = 0.
  - Bank contents and seq_len are not cleared (SRAM-like), so a reset mid-run abandons the run but keeps the weights.
- Widths: all data is passed through unchanged. mdata_r for seq_len is the 20-bit register as written.

Test Plan:
- Config W_ih[{h=5,x=3}]=20'h0ABCD, b_hh[63]=20'hFFFFF; engine reads msel=000,maddr=0x00A3 and msel=011,maddr=63 with mce=1 -> mdata_r=0x0ABCD then 0xFFFFF in the same cycle. mce=0 -> mdata_r=0.
- Set seq_len=3, push 2 vectors (0x12345678, 0x9ABCDEF0), start -> ready=1. Engine raises busy -> ready=0 next cycle. i_en cycle 1 -> idata=0x12345678, popped; i_en cycle 2 -> idata=0x9ABCDEF0.
- In RUN, engine writes msel=101, maddr=0x00041, mdata_w=0x00123 -> next cycle out_valid=1, out_addr=0x00041, out_data=0x00123. busy falls -> single done pulse.
- Read msel=001, maddr=64 -> mdata_r=0, err=1 and stays 1 until reset. Separately, cfg_we during RUN -> the bank is unchanged and err=1.
- FIFO_DEPTH=4: push 4 vectors -> in_ready=0. A 5th push is refused. Pop plus attempted push while full -> occupancy 3. Pop from an empty FIFO -> err=1.
- Reset asserted mid-RUN -> next cycle IDLE, ready=0, FIFO empty. A subsequent read of the previously configured W_hh entry returns its old value.

Source files
------------

// File: rtl/rnn_mem_responder_if.sv
// Engine-side bus of the RNN memory responder: memory port, input-vector pull
// and run handshake.
interface rnn_mem_responder_if #(
   parameter int X  = 32,
   parameter int DW = 20
);
   logic          busy;
   logic          ready;
   logic          i_en;
   logic [X-1:0]  idata;
   logic          mce;
   logic [2:0]    msel;
   logic [16:0]   maddr;
   logic [DW-1:0] mdata_w;
   logic [DW-1:0] mdata_r;

   modport master (output busy, i_en, mce, msel, maddr, mdata_w,
                   input  ready, idata, mdata_r);
   modport slave  (input  busy, i_en, mce, msel, maddr, mdata_w,
                   output ready, idata, mdata_r);
endinterface

// File: rtl/rnn_mem_responder.sv
// Weight/bias/header banks, input-vector FIFO and run sequencer feeding the RNN
// engine; hidden-state writes from the engine are forwarded on out_*.
module rnn_mem_responder #(
   parameter int H          = 64,
   parameter int X          = 32,
   parameter int DW         = 20,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_we,
   input  logic [2:0]    cfg_sel,
   input  logic [16:0]   cfg_addr,
   input  logic [DW-1:0] cfg_data,
   input  logic          in_valid,
   input  logic [X-1:0]  in_data,
   output logic          in_ready,
   input  logic          start,
   output logic          out_valid,
   output logic [16:0]   out_addr,
   output logic [DW-1:0] out_data,
   output logic          done,
   output logic          err,
   rnn_mem_responder_if.slave eng
);
   localparam int HW    = $clog2(H);
   localparam int XW    = $clog2(X);
   localparam int IH_AW = HW + XW;
   localparam int HH_AW = 2 * HW;
   localparam int PW    = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;
   state_t state, state_nxt;

   logic [DW-1:0] w_ih [H*X];
   logic [DW-1:0] b_ih [H];
   logic [DW-1:0] w_hh [H*H];
   logic [DW-1:0] b_hh [H];
   logic [DW-1:0] seq_len;

   logic [X-1:0]  fifo [FIFO_DEPTH];
   logic [PW:0]   wr_ptr, rd_ptr;
   logic          empty, full, push, pop, pull_ok;
   logic          cfg_ok, wr_out, rd_bad;
   logic [DW-1:0] rd_data;

   function automatic logic fits(input logic [16:0] a, input int w);
      return (a >> w) == 17'd0;
   endfunction

   // Combinational read: data valid in the same cycle the address is presented.
   always_comb begin
      rd_data = '0;
      rd_bad  = 1'b0;
      if (eng.mce) begin
         unique case (eng.msel)
            3'b000: if (fits(eng.maddr, IH_AW)) rd_data = w_ih[eng.maddr[IH_AW-1:0]];
                    else rd_bad = 1'b1;
            3'b001: if (fits(eng.maddr, HW)) rd_data = b_ih[eng.maddr[HW-1:0]];
                    else rd_bad = 1'b1;
            3'b010: if (fits(eng.maddr, HH_AW)) rd_data = w_hh[eng.maddr[HH_AW-1:0]];
                    else rd_bad = 1'b1;
            3'b011: if (fits(eng.maddr, HW)) rd_data = b_hh[eng.maddr[HW-1:0]];
                    else rd_bad = 1'b1;
            3'b100: if (eng.maddr == 17'd0) rd_data = seq_len;
            default: ;
         endcase
      end
   end
   assign eng.mdata_r = rd_data;

   assign cfg_ok = cfg_we && (state == S_IDLE || state == S_DONE);
   assign wr_out = eng.mce && eng.msel == 3'b101;

   // Banks are SRAM-like: never reset, so weights survive an aborted run.
   always_ff @(posedge clk) begin
      if (cfg_ok) begin
         unique case (cfg_sel)
            3'b000: if (fits(cfg_addr, IH_AW)) w_ih[cfg_addr[IH_AW-1:0]] <= cfg_data;
            3'b001: if (fits(cfg_addr, HW))    b_ih[cfg_addr[HW-1:0]]    <= cfg_data;
            3'b010: if (fits(cfg_addr, HH_AW)) w_hh[cfg_addr[HH_AW-1:0]] <= cfg_data;
            3'b011: if (fits(cfg_addr, HW))    b_hh[cfg_addr[HW-1:0]]    <= cfg_data;
            3'b100: if (cfg_addr == 17'd0)     seq_len <= cfg_data;
            default: ;
         endcase
      end
   end

   // First-word fall-through FIFO; a full FIFO refuses pushes even when popping.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = ((wr_ptr - rd_ptr) == (PW+1)'(FIFO_DEPTH));
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign pull_ok  = eng.i_en && (state == S_ARMED || state == S_RUN);
   assign pop      = pull_ok && !empty;
   assign eng.idata = empty ? '0 : fifo[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr[PW-1:0]] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start)    state_nxt = S_ARMED;
         S_ARMED: if (eng.busy) state_nxt = S_RUN;
         S_RUN:   if (!eng.busy) state_nxt = S_DONE;
         S_DONE:  if (start)    state_nxt = S_ARMED;
         default: state_nxt = S_IDLE;
      endcase
   end
   assign eng.ready = (state == S_ARMED) && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         out_valid <= wr_out && state == S_RUN;
         if (wr_out && state == S_RUN) begin
            out_addr <= eng.maddr;
            out_data <= eng.mdata_w;
         end
         done <= (state == S_RUN) && !eng.busy;
         if (rd_bad || (pull_ok && empty) ||
             (cfg_we && (state == S_ARMED || state == S_RUN)) ||
             (wr_out && state != S_RUN))
            err <= 1'b1;
      end
   end
endmodule
